yarvi_alu_seq: RTL

Parametrised, registered successor to the YARVI combinational ALU. It sits between issue and writeback, behind a valid/ready handshake. It executes the eight RV32I/RV64I integer funct3 operations, plus the RV64 word forms (ADDW/SUBW/SLLW/SRLW/SRAW). Shifts run on an iterative multi-cycle shifter that retires SBPC shift-amount bits per cycle; all other operations complete in one cycle.

---
 rtl/yarvi_alu_seq_pkg.sv | 25 ++
 rtl/yarvi_shift_stage.sv | 31 +++
 rtl/yarvi_alu_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/yarvi_alu_seq_pkg.sv
// Shared definitions for the registered YARVI ALU: funct3 encodings,
// sequencer states and the iterative-shift cycle count.
package yarvi_alu_seq_pkg;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // Number of shifter passes needed to retire all shift-amount bits.
  function automatic int shift_cycles(input int shw, input int sbpc);
    return (shw + sbpc - 1) / sbpc;
  endfunction

endpackage

// File: rtl/yarvi_shift_stage.sv
// Combinational slice of the iterative shifter: applies SBPC conditional
// power-of-two shifts, starting at log-stage BASE, in one direction.
module yarvi_shift_stage #(
  parameter int XLEN = 64,
  parameter int SBPC = 1,
  parameter int BASE = 0
) (
  input  logic [XLEN-1:0] data,
  input  logic [SBPC-1:0] bits,
  input  logic            right,
  input  logic            fill,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] chain_s [SBPC+1];

  assign chain_s[0] = data;

  for (genvar i = 0; i < SBPC; i++) begin : g_bit
    localparam int D = 1 << (BASE + i);
    logic [XLEN-1:0] moved_s;

    // Right shifts pull the fill bit into the vacated top positions.
    assign moved_s = right ? ((chain_s[i] >> D) | ({XLEN{fill}} << (XLEN - D)))
                           : (chain_s[i] << D);
    assign chain_s[i+1] = bits[i] ? moved_s : chain_s[i];
  end

  assign result = chain_s[SBPC];

endmodule

// File: rtl/yarvi_alu_seq.sv
// Registered YARVI ALU behind valid/ready: single-cycle arithmetic/logic,
// multi-cycle iterative shifts, RV64 word forms.
module yarvi_alu_seq #(
  parameter int XLEN = 64,
  parameter int SBPC = 1,
  parameter int TAGW = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            insn30,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] out_tag
);

  import yarvi_alu_seq_pkg::*;

  localparam int   SHW  = $clog2(XLEN);
  localparam int   SC   = shift_cycles(SHW, SBPC);
  localparam int   CW   = (SC > 1) ? $clog2(SC) : 1;
  localparam int   NSEL = 1 << CW;
  localparam logic IS64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{1'b0}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  state_e          state_r;
  state_e          state_next_s;
  logic            out_valid_r;
  logic [XLEN-1:0] result_r;
  logic [TAGW-1:0] out_tag_r;
  logic [TAGW-1:0] tag_r;
  logic [XLEN-1:0] acc_r;
  logic [SHW-1:0]  shamt_r;
  logic            right_r;
  logic            fill_r;
  logic            word_r;
  logic [CW-1:0]   cnt_r;

  logic            in_ready_s;
  logic            accept_s;
  logic            is_shift_s;
  logic            word_s;
  logic            last_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] src_s;
  logic            fill_s;
  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] shift_sel_s;
  logic [XLEN-1:0] shift_res_s;
  logic [XLEN-1:0] stage_out_s [NSEL];

  assign in_ready_s = (state_r != ST_SHIFT) & (~out_valid_r | out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign is_shift_s = (funct3 == F3_SLL) | (funct3 == F3_SR);
  assign word_s     = word & IS64;
  assign last_s     = (cnt_r == CW'(SC - 1));

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign out_tag   = out_tag_r;

  // Single-cycle arithmetic, compare and logic operations
  always_comb begin
    sum_s = op1 + (op2 ^ {XLEN{insn30}}) + {{(XLEN-1){1'b0}}, insn30};
    case (funct3)
      F3_ADDSUB: alu_s = word_s ? sext32(sum_s) : sum_s;
      F3_SLT:    alu_s = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      F3_SLTU:   alu_s = {{(XLEN-1){1'b0}}, (op1 < op2)};
      F3_XOR:    alu_s = op1 ^ op2;
      F3_OR:     alu_s = op1 | op2;
      F3_AND:    alu_s = op1 & op2;
      default:   alu_s = {XLEN{1'b0}};
    endcase
  end

  // Shift operand preparation: word forms narrow the operand and the amount
  always_comb begin
    shamt_s = op2[SHW-1:0];
    if (word_s) begin
      src_s            = ((funct3 == F3_SR) && insn30) ? sext32(op1) : zext32(op1);
      shamt_s[SHW-1]   = 1'b0;
    end else begin
      src_s = op1;
    end
    fill_s = insn30 & (funct3 == F3_SR) & src_s[XLEN-1];
  end

  // One shifter slice per pass; the pass counter picks which slice is live.
  for (genvar c = 0; c < NSEL; c++) begin : g_stage
    if (c < SC) begin : g_act
      localparam int NB = ((SHW - c * SBPC) < SBPC) ? (SHW - c * SBPC) : SBPC;
      yarvi_shift_stage #(
        .XLEN (XLEN),
        .SBPC (NB),
        .BASE (c * SBPC)
      ) u_stage (
        .data   (acc_r),
        .bits   (shamt_r[c*SBPC +: NB]),
        .right  (right_r),
        .fill   (fill_r),
        .result (stage_out_s[c])
      );
    end else begin : g_pad
      assign stage_out_s[c] = acc_r;
    end
  end

  assign shift_sel_s = stage_out_s[cnt_r];
  assign shift_res_s = word_r ? sext32(shift_sel_s) : shift_sel_s;

  // Sequencer state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = is_shift_s ? ST_SHIFT : ST_EXEC;
        else          state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_s) state_next_s = ST_EXEC;
        else        state_next_s = ST_SHIFT;
      end
      ST_EXEC: begin
        if (accept_s)       state_next_s = is_shift_s ? ST_SHIFT : ST_EXEC;
        else if (out_ready) state_next_s = ST_IDLE;
        else                state_next_s = ST_EXEC;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture, shift accumulator, pass counter and output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      out_tag_r   <= {TAGW{1'b0}};
      tag_r       <= {TAGW{1'b0}};
      acc_r       <= {XLEN{1'b0}};
      shamt_r     <= {SHW{1'b0}};
      right_r     <= 1'b0;
      fill_r      <= 1'b0;
      word_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
    end else if (accept_s) begin
      acc_r   <= src_s;
      shamt_r <= shamt_s;
      right_r <= (funct3 == F3_SR);
      fill_r  <= fill_s;
      word_r  <= word_s;
      tag_r   <= in_tag;
      cnt_r   <= {CW{1'b0}};
      if (is_shift_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b1;
        result_r    <= alu_s;
        out_tag_r   <= in_tag;
      end
    end else if (state_r == ST_SHIFT) begin
      acc_r <= shift_sel_s;
      cnt_r <= cnt_r + CW'(1);
      if (last_s) begin
        out_valid_r <= 1'b1;
        result_r    <= shift_res_s;
        out_tag_r   <= tag_r;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule
